// File: rtl/cache_bus_arbiter.sv
// Arbitrates the shared 128-bit memory bus between I-cache refills and D-cache traffic.
// Optional ARB_ROUND_ROBIN_EN: tie-break by last-served instead of fixed D priority.
module cache_bus_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 128,
    parameter int LOCK_MAX_BEATS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_req_i,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    output logic                  i_ack_o,
    output logic [DATA_WIDTH-1:0] i_data_o,
    input  logic                  d_req_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic                  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_data_i,
    input  logic                  d_lock_i,
    output logic                  d_ack_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  mem_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [1:0]            grant_o
);
    localparam int BW = $clog2(LOCK_MAX_BEATS + 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(LOCK_MAX_BEATS);
    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_I    = 2'b01;
    localparam logic [1:0] G_D    = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DROP, HOLD} state_t;

    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            grant_q, grant_d;
    logic [BW-1:0]         beats_q, beats_d;
    logic                  pick_d, owner_d, owner_req;

    assign owner_d   = (grant_q == G_D);
    assign owner_req = owner_d ? d_req_i : i_req_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;
    assign pick_d = d_req_i & (~i_req_i | ~last_d_q);
`else
    assign pick_d = d_req_i;
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        we_d    = we_q;
        data_d  = data_q;
        grant_d = grant_q;
        beats_d = beats_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d = last_d_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_req_i | d_req_i) begin
                    state_d = BUSY;
                    valid_d = 1'b1;
                    beats_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = pick_d;
`endif
                    if (pick_d) begin
                        addr_d  = d_addr_i;
                        we_d    = d_we_i;
                        data_d  = d_data_i;
                        grant_d = G_D;
                    end else begin
                        addr_d  = i_addr_i;
                        we_d    = 1'b0;
                        data_d  = '0;
                        grant_d = G_I;
                    end
                end
            end
            BUSY: begin
                if (mem_valid_i) begin
                    valid_d = 1'b0;
                    state_d = DROP;
                    // Completed locked D beats feed the starvation limit.
                    if (owner_d && d_lock_i && beats_q != BEAT_MAX)
                        beats_d = beats_q + 1'b1;
                end
            end
            DROP: begin
                if (!owner_req) begin
                    if (owner_d && d_lock_i &&
                        !(beats_q == BEAT_MAX && i_req_i)) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        grant_d = G_NONE;
                    end
                end
            end
            HOLD: begin
                if (d_req_i) begin
                    state_d = BUSY;
                    valid_d = 1'b1;
                    addr_d  = d_addr_i;
                    we_d    = d_we_i;
                    data_d  = d_data_i;
                end else if (!d_lock_i) begin
                    state_d = IDLE;
                    grant_d = G_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            data_q  <= '0;
            grant_q <= G_NONE;
            beats_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            beats_q <= beats_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    // Acks only reach the current owner, and only while a request is outstanding.
    assign i_ack_o     = (state_q == BUSY) & (grant_q == G_I) & mem_valid_i;
    assign d_ack_o     = (state_q == BUSY) & owner_d & mem_valid_i;
    assign i_data_o    = mem_data_i;
    assign d_data_o    = mem_data_i;
    assign mem_valid_o = valid_q;
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_data_o  = data_q;
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Scoreboard bench for cache_bus_arbiter (LOCK_MAX_BEATS=2).
// Memory responder echoes {8{addr}} unless a fixed pattern is forced.
module tb_cache_bus_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_req, i_ack;
    logic [15:0]  i_addr;
    logic [127:0] i_rdata;
    logic         d_req, d_we, d_lock, d_ack;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata, d_rdata;
    logic         mv_o, mwe_o;
    logic [15:0]  maddr_o;
    logic [127:0] mdata_o;
    logic         mem_valid_i;
    logic [127:0] mem_data_i;
    logic [1:0]   grant;

    logic         rsp_vld, inj_vld, rsp_en, rsp_force;
    logic [127:0] rsp_fixed;
    int           rsp_lat;
    int           n_checks = 0;
    int           n_fail = 0;

    assign mem_valid_i = rsp_vld | inj_vld;

    cache_bus_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(128), .LOCK_MAX_BEATS(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_ack_o(i_ack), .i_data_o(i_rdata),
        .d_req_i(d_req), .d_addr_i(d_addr), .d_we_i(d_we), .d_data_i(d_wdata),
        .d_lock_i(d_lock), .d_ack_o(d_ack), .d_data_o(d_rdata),
        .mem_valid_o(mv_o), .mem_addr_o(maddr_o), .mem_we_o(mwe_o),
        .mem_data_o(mdata_o), .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
        .grant_o(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        logic [15:0]  addr;
        bit           we;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    exp_t req_q[$];
    exp_t ack_q[$];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout expected response", nm);
    endtask

    function automatic void expect_txn(input bit is_d, input logic [15:0] a,
                                       input bit we, input logic [127:0] wd,
                                       input logic [127:0] rd);
        exp_t e;
        e.is_d = is_d; e.addr = a; e.we = we; e.wdata = wd; e.rdata = rd;
        req_q.push_back(e);
        ack_q.push_back(e);
    endfunction

    // Memory responder: ack rsp_lat cycles after a request is presented.
    initial begin
        int cnt = 0;
        rsp_vld = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_vld) begin
                rsp_vld = 1'b0;
                cnt = 0;
            end else if (mv_o && rsp_en) begin
                cnt++;
                if (cnt >= rsp_lat) begin
                    rsp_vld = 1'b1;
                    mem_data_i = rsp_force ? rsp_fixed : {8{maddr_o}};
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops expectations on new bus requests and on acks.
    initial begin
        bit prev_mv = 1'b0;
        bit prev_ack = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_ack) chk("mem_valid_after_ack", 128'(mv_o), 128'(0));
            if (i_ack && d_ack) chk("dual_ack", 128'(1), 128'(0));
            if (i_ack || d_ack) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 128'(1), 128'(0));
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_owner_d", 128'(d_ack), 128'(e.is_d));
                    chk("ack_grant", 128'(grant), e.is_d ? 128'(2) : 128'(1));
                    chk("ack_data", e.is_d ? d_rdata : i_rdata, e.rdata);
                end
            end
            if (mv_o && !prev_mv) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 128'(1), 128'(0));
                end else begin
                    e = req_q.pop_front();
                    chk("req_grant", 128'(grant), e.is_d ? 128'(2) : 128'(1));
                    chk("req_addr", 128'(maddr_o), 128'(e.addr));
                    chk("req_we", 128'(mwe_o), 128'(e.we));
                    if (e.we) chk("req_wdata", mdata_o, e.wdata);
                end
            end
            prev_mv = mv_o;
            prev_ack = i_ack | d_ack;
        end
    end

    task automatic i_issue(input logic [15:0] a);
        int n = 0;
        i_addr = a;
        i_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ack && n < 200);
        if (!i_ack) timeout("i_ack_wait");
        @(posedge clk);
        #1 i_req = 1'b0;
    endtask

    task automatic d_issue(input logic [15:0] a, input bit we,
                           input logic [127:0] wd);
        int n = 0;
        d_addr = a;
        d_we = we;
        d_wdata = wd;
        d_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ack && n < 200);
        if (!d_ack) timeout("d_ack_wait");
        @(posedge clk);
        #1 d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bit m_last_d = 1'b0;
        bit first_d;
        int n;
        rst_n = 1'b0;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
        inj_vld = 0; rsp_en = 1; rsp_force = 0; rsp_fixed = '0; rsp_lat = 2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", 128'(mv_o), 128'(0));
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_mem_we", 128'(mwe_o), 128'(0));
        chk("rst_mem_addr", 128'(maddr_o), 128'(0));
        chk("rst_mem_data", mdata_o, 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // I-only read with 3-cycle memory latency
        rsp_lat = 3;
        rsp_force = 1;
        rsp_fixed = {16{8'hA5}};
        expect_txn(0, 16'h0123, 0, '0, {16{8'hA5}});
        fork
            i_issue(16'h0123);
            begin
                chk("i_latency_pre", 128'(mv_o), 128'(0));
                @(posedge clk);
                #1;
                chk("i_latency_mv", 128'(mv_o), 128'(1));
                chk("i_latency_grant", 128'(grant), 128'(1));
            end
        join
        @(posedge clk);
        #1;
        chk("i_grant_release", 128'(grant), 128'(0));
        rsp_force = 0;
        rsp_lat = 2;

        // D write-back
        expect_txn(1, 16'h0040, 1, {8{16'h1111}}, {8{16'h0040}});
        d_issue(16'h0040, 1, {8{16'h1111}});
        chk("d_grant_release", 128'(grant), 128'(0));

        // Two simultaneous I/D request rounds
        for (int r = 0; r < 2; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
            first_d = !m_last_d;
`else
            first_d = 1'b1;
`endif
            if (first_d) begin
                expect_txn(1, 16'h0300 + 16'(r), 0, '0, {8{16'h0300 + 16'(r)}});
                expect_txn(0, 16'h0200 + 16'(r), 0, '0, {8{16'h0200 + 16'(r)}});
            end else begin
                expect_txn(0, 16'h0200 + 16'(r), 0, '0, {8{16'h0200 + 16'(r)}});
                expect_txn(1, 16'h0300 + 16'(r), 0, '0, {8{16'h0300 + 16'(r)}});
            end
            m_last_d = !first_d;
            fork
                i_issue(16'h0200 + 16'(r));
                d_issue(16'h0300 + 16'(r), 0, '0);
            join
            repeat (2) @(posedge clk);
            #1;
        end

        // Lock held, no I pending: 4 D beats keep the grant
        d_lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_txn(1, 16'h0400 + 16'(k), 1, {8{16'hBEEF}}, {8{16'h0400 + 16'(k)}});
            d_issue(16'h0400 + 16'(k), 1, {8{16'hBEEF}});
            chk("lock_grant_hold", 128'(grant), 128'(2));
        end
        expect_txn(0, 16'h0500, 0, '0, {8{16'h0500}});
        fork
            i_issue(16'h0500);
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("lock_i_blocked_grant", 128'(grant), 128'(2));
                chk("lock_i_blocked_mv", 128'(mv_o), 128'(0));
                d_lock = 1'b0;
            end
        join
        @(posedge clk);
        #1;

        // Beat limit of 2 releases the bus to a waiting I request
        d_lock = 1'b1;
        expect_txn(1, 16'h0600, 0, '0, {8{16'h0600}});
        expect_txn(1, 16'h0601, 0, '0, {8{16'h0601}});
        expect_txn(0, 16'h0700, 0, '0, {8{16'h0700}});
        for (int k = 2; k < 5; k++)
            expect_txn(1, 16'h0600 + 16'(k), 0, '0, {8{16'h0600 + 16'(k)}});
        fork
            for (int k = 0; k < 5; k++) d_issue(16'h0600 + 16'(k), 0, '0);
            begin
                @(posedge clk);
                #1;
                i_issue(16'h0700);
            end
        join
        chk("starve_lock_hold", 128'(grant), 128'(2));
        d_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("starve_unlock_grant", 128'(grant), 128'(0));

        // Reset while a request is outstanding; late ack must be dropped
        rsp_en = 0;
        req_q.push_back('{0, 16'h0777, 0, '0, '0});
        i_addr = 16'h0777;
        i_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mv_o && n < 50);
        if (!mv_o) timeout("rst_mid_busy_wait");
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_mv", 128'(mv_o), 128'(0));
        chk("rst_mid_grant", 128'(grant), 128'(0));
        i_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 inj_vld = 1'b1;
        #1;
        chk("late_ack_i", 128'(i_ack), 128'(0));
        chk("late_ack_d", 128'(d_ack), 128'(0));
        @(posedge clk);
        #1 inj_vld = 1'b0;
        rsp_en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("req_queue_drained", 128'(req_q.size()), 128'(0));
        chk("ack_queue_drained", 128'(ack_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1);
    end
endmodule
